// File: rtl/mhp_rx.sv
// Receive-side frame parser: pulls a 7-byte header from the byte source, decodes
// the opcode into a task number, then forwards or discards the payload.
module mhp_rx #(
    parameter logic [15:0] MAX_SIZE = 16'd1500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [7:0]  i_rdata,
    input  logic        i_rready,
    output logic        o_rreq,
    output logic [15:0] o_dst,
    output logic [15:0] o_src,
    output logic [15:0] o_size,
    output logic [6:0]  o_dtype,
    output logic        o_dir,
    output logic        o_hdrValid,
    output logic [15:0] o_taskNbr,
    output logic        o_taskStart,
    output logic [7:0]  o_pdata,
    output logic        o_pvalid,
    input  logic        i_pready,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DROP, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  hdr_cnt_reg;
    logic [15:0] rem_reg;
    logic [15:0] dst_hold_reg, src_hold_reg, size_hold_reg;
    logic [15:0] dst_reg, src_reg, size_reg, task_nbr_reg;
    logic [6:0]  dtype_reg;
    logic        dir_reg, hdr_valid_reg, task_start_reg, err_reg;
    logic        xfer, hdr_last, task_known;
    logic [15:0] task_nbr_dec;

    // Transfer qualifier derived from state directly so it never loops through o_rreq.
    assign xfer = i_rready & ((state_reg == HDR) || (state_reg == DROP) ||
                              ((state_reg == PAYLOAD) && i_pready));
    assign hdr_last = (state_reg == HDR) && xfer && (hdr_cnt_reg == 3'd6);

    always_comb begin
        task_known   = 1'b1;
        task_nbr_dec = 16'h0000;
        case (i_rdata[6:0])
            7'h03:   task_nbr_dec = 16'h0010;
            7'h01:   task_nbr_dec = 16'h0020;
            7'h05:   task_nbr_dec = 16'h0030;
            default: task_known = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        o_rreq     = 1'b0;
        o_pvalid   = 1'b0;
        o_pdata    = 8'h00;
        o_done     = 1'b0;
        case (state_reg)
            IDLE: if (i_enable) state_next = HDR;
            HDR: begin
                o_rreq = 1'b1;
                if (hdr_last) begin
                    if (size_hold_reg == 16'd0)
                        state_next = DONE;
                    else if (size_hold_reg > MAX_SIZE)
                        state_next = DROP;
                    else
                        state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                o_rreq   = i_pready;
                o_pvalid = i_rready;
                o_pdata  = i_rdata;
                if (xfer && rem_reg == 16'd1) state_next = DONE;
            end
            DROP: begin
                o_rreq = 1'b1;
                if (xfer && rem_reg == 16'd1) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            hdr_cnt_reg    <= 3'd0;
            rem_reg        <= 16'd0;
            dst_hold_reg   <= 16'd0;
            src_hold_reg   <= 16'd0;
            size_hold_reg  <= 16'd0;
            dst_reg        <= 16'd0;
            src_reg        <= 16'd0;
            size_reg       <= 16'd0;
            dtype_reg      <= 7'd0;
            dir_reg        <= 1'b0;
            hdr_valid_reg  <= 1'b0;
            task_nbr_reg   <= 16'd0;
            task_start_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hdr_valid_reg  <= 1'b0;
            task_start_reg <= 1'b0;
            case (state_reg)
                IDLE: if (i_enable) begin
                    hdr_cnt_reg <= 3'd0;
                    err_reg     <= 1'b0;
                end
                HDR: if (xfer) begin
                    hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
                    case (hdr_cnt_reg)
                        3'd0: dst_hold_reg[15:8]  <= i_rdata;
                        3'd1: dst_hold_reg[7:0]   <= i_rdata;
                        3'd2: src_hold_reg[15:8]  <= i_rdata;
                        3'd3: src_hold_reg[7:0]   <= i_rdata;
                        3'd4: size_hold_reg[15:8] <= i_rdata;
                        3'd5: size_hold_reg[7:0]  <= i_rdata;
                        3'd6: begin
                            // Visible header outputs change only here, so they hold across frames.
                            dst_reg        <= dst_hold_reg;
                            src_reg        <= src_hold_reg;
                            size_reg       <= size_hold_reg;
                            dtype_reg      <= i_rdata[6:0];
                            dir_reg        <= i_rdata[7];
                            hdr_valid_reg  <= 1'b1;
                            task_nbr_reg   <= task_nbr_dec;
                            task_start_reg <= task_known;
                            err_reg        <= !task_known || (size_hold_reg > MAX_SIZE);
                            rem_reg        <= size_hold_reg;
                        end
                        default: ;
                    endcase
                end
                PAYLOAD, DROP: if (xfer) rem_reg <= rem_reg - 16'd1;
                default: ;
            endcase
        end
    end

    assign o_dst       = dst_reg;
    assign o_src       = src_reg;
    assign o_size      = size_reg;
    assign o_dtype     = dtype_reg;
    assign o_dir       = dir_reg;
    assign o_hdrValid  = hdr_valid_reg;
    assign o_taskNbr   = task_nbr_reg;
    assign o_taskStart = task_start_reg;
    assign o_err       = err_reg;

endmodule

// File: tb/tb_mhp_rx.sv
// Randomized bench for mhp_rx: frames are built from field values and checked
// against expectations derived from the frame contents.
module tb_mhp_rx;

    logic        clk = 1'b0;
    logic        rst_n, enable, rready, pready;
    logic [7:0]  rdata;
    logic        o_rreq, o_dir, o_hdrValid, o_taskStart, o_pvalid, o_done, o_err;
    logic [15:0] o_dst, o_src, o_size, o_taskNbr;
    logic [6:0]  o_dtype;
    logic [7:0]  o_pdata;

    int vectors = 0;
    int miscompares = 0;

    localparam int MAX = 1500;

    always #5 clk = ~clk;

    mhp_rx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
        .i_rdata(rdata), .i_rready(rready), .o_rreq(o_rreq),
        .o_dst(o_dst), .o_src(o_src), .o_size(o_size),
        .o_dtype(o_dtype), .o_dir(o_dir), .o_hdrValid(o_hdrValid),
        .o_taskNbr(o_taskNbr), .o_taskStart(o_taskStart),
        .o_pdata(o_pdata), .o_pvalid(o_pvalid), .i_pready(pready),
        .o_done(o_done), .o_err(o_err)
    );

    function automatic logic [15:0] model_task(input logic [6:0] op);
        case (op)
            7'h03:   return 16'h0010;
            7'h01:   return 16'h0020;
            7'h05:   return 16'h0030;
            default: return 16'h0000;
        endcase
    endfunction

    // Drives one frame through the byte source and checks everything observed.
    task automatic run_frame(input logic [15:0] dst, input logic [15:0] src,
                             input logic [15:0] size, input logic [7:0] dtype,
                             input int rr_pct, input int pr_pct, input int stall_at,
                             input int abort_after, input logic en_hold);
        logic [7:0]  q[$];
        logic [7:0]  pay[$];
        logic [7:0]  got[$];
        logic [7:0]  b;
        logic [15:0] exp_task;
        logic        exp_drop, exp_err, aborted, pay_bad;
        int consumed, cyc, budget, hdr_seen, done_seen, hdr_cyc, hdr_xfer_cyc;
        int last_xfer, done_cyc, bad, stall_left, n_chk;
        q.push_back(dst[15:8]);  q.push_back(dst[7:0]);
        q.push_back(src[15:8]);  q.push_back(src[7:0]);
        q.push_back(size[15:8]); q.push_back(size[7:0]);
        q.push_back(dtype);
        for (int i = 0; i < int'(size); i++) begin
            b = 8'($urandom);
            q.push_back(b);
            pay.push_back(b);
        end
        exp_task = model_task(dtype[6:0]);
        exp_drop = int'(size) > MAX;
        exp_err  = (exp_task == 16'h0000) || exp_drop;
        if (exp_drop) pay.delete();
        budget = (7 + int'(size)) * 30 + 20;
        consumed = 0; hdr_seen = 0; done_seen = 0; bad = 0; stall_left = 5;
        hdr_cyc = -1; hdr_xfer_cyc = -10; last_xfer = -10; done_cyc = -1;
        aborted = 1'b0;
        cyc = 0;
        while (done_seen == 0 && !aborted && cyc < budget) begin
            @(negedge clk);
            enable = (cyc == 0) ? 1'b1 : en_hold;
            rready = ($urandom_range(99) < rr_pct);
            if (stall_at >= 0 && consumed == stall_at && stall_left > 0) begin
                rready = 1'b0;
                stall_left--;
            end
            rdata  = (consumed < q.size()) ? q[consumed] : 8'($urandom);
            pready = ($urandom_range(99) < pr_pct);
            #1;
            if (o_hdrValid) begin
                hdr_seen++;
                hdr_cyc = cyc;
                vectors += 8;
                if (o_dst !== dst) begin miscompares++; $display("FAIL hdr_dst: got %h expected %h", o_dst, dst); end
                if (o_src !== src) begin miscompares++; $display("FAIL hdr_src: got %h expected %h", o_src, src); end
                if (o_size !== size) begin miscompares++; $display("FAIL hdr_size: got %h expected %h", o_size, size); end
                if (o_dtype !== dtype[6:0]) begin miscompares++; $display("FAIL hdr_dtype: got %h expected %h", o_dtype, dtype[6:0]); end
                if (o_dir !== dtype[7]) begin miscompares++; $display("FAIL hdr_dir: got %b expected %b", o_dir, dtype[7]); end
                if (o_taskNbr !== exp_task) begin miscompares++; $display("FAIL task_nbr: got %h expected %h", o_taskNbr, exp_task); end
                if (o_taskStart !== (exp_task != 16'h0000)) begin miscompares++; $display("FAIL task_start: got %b expected %b", o_taskStart, exp_task != 16'h0000); end
                if (o_err !== exp_err) begin miscompares++; $display("FAIL hdr_err: got %b expected %b", o_err, exp_err); end
            end
            if (o_done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if ((hdr_seen == 0 || done_seen > 0 || exp_drop) && (o_pvalid !== 1'b0 || o_pdata !== 8'h00)) bad++;
            if (o_pvalid && pready) got.push_back(o_pdata);
            if (o_rreq && rready) begin
                consumed++;
                last_xfer = cyc;
                if (consumed == 7) hdr_xfer_cyc = cyc;
            end
            if (abort_after > 0 && got.size() == abort_after) aborted = 1'b1;
            cyc++;
        end

        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b0;
            enable = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if ({o_rreq, o_dst, o_src, o_size, o_dtype, o_dir, o_hdrValid, o_taskNbr,
                 o_taskStart, o_pvalid, o_pdata, o_done, o_err} !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_outputs: got rreq=%b dst=%h src=%h size=%h err=%b pvalid=%b done=%b expected all zero",
                         o_rreq, o_dst, o_src, o_size, o_err, o_pvalid, o_done);
            end
            @(negedge clk);
            rst_n = 1'b1;
            n_chk = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                rready = 1'b1;
                #1;
                if (o_done !== 1'b0 || o_rreq !== 1'b0) n_chk++;
            end
            vectors++;
            if (n_chk != 0) begin miscompares++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", n_chk); end
            vectors++;
            if (got[0] !== pay[0] || got[1] !== pay[1]) begin
                miscompares++;
                $display("FAIL reset_mid_prefix: got %h %h expected %h %h", got[0], got[1], pay[0], pay[1]);
            end
            $display("frame dst=%h size=%0d aborted by reset after %0d payload bytes", dst, size, got.size());
            return;
        end

        vectors++;
        if (done_seen == 0) begin
            miscompares++;
            $display("FAIL frame_timeout: got no done in %0d cycles expected done", budget);
        end
        vectors++;
        if (consumed != 7 + int'(size)) begin miscompares++; $display("FAIL consumed: got %0d expected %0d", consumed, 7 + int'(size)); end
        vectors++;
        if (hdr_seen != 1 || hdr_cyc != hdr_xfer_cyc + 1) begin
            miscompares++;
            $display("FAIL hdr_timing: got %0d strobes at cycle %0d expected 1 at cycle %0d", hdr_seen, hdr_cyc, hdr_xfer_cyc + 1);
        end
        vectors++;
        if (done_cyc != last_xfer + 1) begin miscompares++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_xfer + 1); end
        pay_bad = (got.size() != pay.size());
        for (int i = 0; i < got.size() && i < pay.size(); i++)
            if (got[i] !== pay[i]) pay_bad = 1'b1;
        vectors++;
        if (pay_bad) begin miscompares++; $display("FAIL payload: got %0d bytes expected %0d bytes with matching data", got.size(), pay.size()); end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL pvalid_outside_payload: got %0d cycles expected 0", bad); end

        @(negedge clk);
        enable = en_hold;
        rready = 1'b1;
        pready = 1'b1;
        #1;
        vectors++;
        if (o_done !== 1'b0 || o_rreq !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: got done=%b rreq=%b expected 0 0", o_done, o_rreq);
        end
        vectors++;
        if (o_dst !== dst || o_err !== exp_err || o_taskNbr !== exp_task) begin
            miscompares++;
            $display("FAIL hold: got dst=%h err=%b task=%h expected %h %b %h", o_dst, o_err, o_taskNbr, dst, exp_err, exp_task);
        end
        $display("frame dst=%h src=%h size=%0d dtype=%h payload=%0d err=%b", dst, src, size, dtype, got.size(), o_err);
    endtask

    task automatic test_reset();
        int n_rreq;
        rst_n = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rready = 1'b1;
            pready = 1'b1;
            rdata  = 8'($urandom);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({o_rreq, o_dst, o_src, o_size, o_dtype, o_dir, o_hdrValid, o_taskNbr,
             o_taskStart, o_pvalid, o_pdata, o_done, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rreq=%b dst=%h pdata=%h done=%b err=%b expected all zero",
                     o_rreq, o_dst, o_pdata, o_done, o_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        n_rreq = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (o_rreq !== 1'b0) n_rreq++;
        end
        vectors++;
        if (n_rreq != 0) begin miscompares++; $display("FAIL enable_blocks: got %0d rreq cycles expected 0", n_rreq); end
        $display("reset checked");
    endtask

    task automatic test_basic();
        run_frame(16'hFFFF, 16'h0000, 16'h0000, 8'h83, 100, 100, -1, -1, 1'b0);
    endtask

    task automatic test_payload();
        run_frame(16'h1234, 16'h5678, 16'h0003, 8'h01, 100, 50, -1, -1, 1'b0);
        run_frame(16'h0A0B, 16'h0C0D, 16'h0007, 8'h85, 60, 60, -1, -1, 1'b0);
    endtask

    task automatic test_unknown_opcode();
        run_frame(16'h2222, 16'h3333, 16'h0001, 8'h7F, 100, 100, -1, -1, 1'b0);
        run_frame(16'h4444, 16'h5555, 16'h0002, 8'h00, 80, 80, -1, -1, 1'b0);
    endtask

    task automatic test_max_boundary();
        run_frame(16'h0101, 16'h0202, 16'd1500, 8'h05, 100, 100, -1, -1, 1'b0);
    endtask

    task automatic test_oversize();
        run_frame(16'hBEEF, 16'hCAFE, 16'h05DD, 8'h03, 100, 50, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(16'h9876, 16'h5432, 16'h0002, 8'h03, 100, 100, 4, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_frame(16'h7777, 16'h8888, 16'h0008, 8'h01, 100, 100, -1, 2, 1'b0);
        run_frame(16'h1111, 16'h2222, 16'h0004, 8'h05, 100, 100, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] dt;
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(3))
                0: dt = 8'h03;
                1: dt = 8'h01;
                2: dt = 8'h05;
                default: dt = 8'($urandom);
            endcase
            dt[7] = 1'($urandom);
            run_frame(16'($urandom), 16'($urandom), 16'($urandom_range(40)), dt, 70, 70, -1, -1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            run_frame(16'($urandom), 16'($urandom), 16'($urandom_range(5)), 8'h01, 100, 100, -1, -1, 1'b1);
        run_frame(16'h5A5A, 16'hA5A5, 16'h0002, 8'h03, 100, 100, -1, -1, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        rready = 1'b0;
        pready = 1'b0;
        rdata  = 8'h00;
        test_reset();
        test_basic();
        test_payload();
        test_unknown_opcode();
        test_max_boundary();
        test_oversize();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
